// File: rtl/fp_adder_seq.sv
// fp_adder_seq: iterative floating-point adder/subtractor.
// Format is sign | EXP_W exponent | FRAC_W fraction with a hidden leading 1 and
// bias 2^(EXP_W-1)-1. Exponent 0 encodes zero; there are no denormals, Inf or NaN.
// Alignment and normalisation move one bit per cycle, so latency depends on the
// exponent difference and on how far the raw sum is from normalised.
// Optional feature macro: FP_ADDER_SEQ_RNE_EN adds a one-cycle ROUND state with
// round-to-nearest-even; without it guard/round/sticky are simply truncated.
module fp_adder_seq #(
    parameter int EXP_W  = 4,
    parameter int FRAC_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              op_sub,
    input  logic              sign_a,
    input  logic [EXP_W-1:0]  exp_a,
    input  logic [FRAC_W-1:0] frac_a,
    input  logic              sign_b,
    input  logic [EXP_W-1:0]  exp_b,
    input  logic [FRAC_W-1:0] frac_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              sign_out,
    output logic [EXP_W-1:0]  exp_out,
    output logic [FRAC_W-1:0] frac_out,
    output logic              ovf,
    output logic              unf
);

    // Mantissa: hidden bit, fraction, guard, round, sticky. Sum adds a carry bit.
    localparam int M_W = FRAC_W + 4;
    localparam int S_W = FRAC_W + 5;
    localparam int CAP = FRAC_W + 3;
    localparam int D_W = (EXP_W > $clog2(CAP + 1)) ? EXP_W : $clog2(CAP + 1);

    localparam logic [S_W-1:0] SAT_SUM = {2'b01, {FRAC_W{1'b1}}, 3'b000};

`ifdef FP_ADDER_SEQ_RNE_EN
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_ALIGN = 3'd1, S_ADD = 3'd2, S_NORM = 3'd3, S_DONE = 3'd4, S_ROUND = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_ALIGN = 3'd1, S_ADD = 3'd2, S_NORM = 3'd3, S_DONE = 3'd4
    } state_t;
`endif

    state_t            state_q, state_d;
    logic              sign_q, sign_d;          // result sign (sign of larger operand)
    logic              diff_q, diff_d;          // operand signs differ -> subtract
    logic [EXP_W-1:0]  exp_q, exp_d;            // working exponent
    logic [M_W-1:0]    mant_a_q, mant_a_d;
    logic [M_W-1:0]    mant_b_q, mant_b_d;
    logic [S_W-1:0]    sum_q, sum_d;
    logic [D_W-1:0]    d_q, d_d;
    logic              ovf_n_q, ovf_n_d;        // flags of the result being built
    logic              unf_n_q, unf_n_d;
    logic              out_valid_q, out_valid_d;
    logic              sign_out_q, sign_out_d;
    logic [EXP_W-1:0]  exp_out_q, exp_out_d;
    logic [FRAC_W-1:0] frac_out_q, frac_out_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    // Capture-path helpers: effective B sign, operand ordering, raw exponent gap
    logic              sign_b_eff;
    logic              a_is_big;
    logic              big_s, small_s;
    logic [EXP_W-1:0]  big_e, small_e, exp_gap;
    logic [FRAC_W-1:0] big_f, small_f;
    logic [M_W-1:0]    big_m, small_m;

`ifdef FP_ADDER_SEQ_RNE_EN
    logic              round_up;
    logic [FRAC_W+1:0] rnd;
`endif

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign sign_out  = sign_out_q;
    assign exp_out   = exp_out_q;
    assign frac_out  = frac_out_q;
    assign ovf       = ovf_q;
    assign unf       = unf_q;

    // Next-state and datapath logic for the whole operation sequence
    always_comb begin
        state_d     = state_q;
        sign_d      = sign_q;
        diff_d      = diff_q;
        exp_d       = exp_q;
        mant_a_d    = mant_a_q;
        mant_b_d    = mant_b_q;
        sum_d       = sum_q;
        d_d         = d_q;
        ovf_n_d     = ovf_n_q;
        unf_n_d     = unf_n_q;
        out_valid_d = out_valid_q;
        sign_out_d  = sign_out_q;
        exp_out_d   = exp_out_q;
        frac_out_d  = frac_out_q;
        ovf_d       = ovf_q;
        unf_d       = unf_q;

        sign_b_eff = sign_b ^ op_sub;
        a_is_big   = ({exp_a, frac_a} >= {exp_b, frac_b});
        big_s      = a_is_big ? sign_a : sign_b_eff;
        big_e      = a_is_big ? exp_a  : exp_b;
        big_f      = a_is_big ? frac_a : frac_b;
        small_s    = a_is_big ? sign_b_eff : sign_a;
        small_e    = a_is_big ? exp_b  : exp_a;
        small_f    = a_is_big ? frac_b : frac_a;
        big_m      = (big_e   == '0) ? '0 : {1'b1, big_f,   3'b000};
        small_m    = (small_e == '0) ? '0 : {1'b1, small_f, 3'b000};
        exp_gap    = big_e - small_e;

`ifdef FP_ADDER_SEQ_RNE_EN
        round_up = sum_q[2] & (sum_q[1] | sum_q[0] | sum_q[3]);
        rnd      = {1'b0, sum_q[S_W-2:3]} + (FRAC_W+2)'(round_up);
`endif

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    sign_d   = big_s;
                    diff_d   = big_s ^ small_s;
                    exp_d    = big_e;
                    mant_a_d = big_m;
                    ovf_n_d  = 1'b0;
                    unf_n_d  = 1'b0;
                    if (D_W'(exp_gap) > D_W'(CAP)) begin
                        // Everything of B would be shifted out: keep only its sticky.
                        d_d      = D_W'(CAP);
                        mant_b_d = {{(M_W-1){1'b0}}, |small_m};
                    end else begin
                        d_d      = D_W'(exp_gap);
                        mant_b_d = small_m;
                    end
                    state_d = S_ALIGN;
                end
            end
            S_ALIGN: begin
                if (d_q != '0) begin
                    mant_b_d = {1'b0, mant_b_q[M_W-1:2], mant_b_q[1] | mant_b_q[0]};
                    d_d      = d_q - D_W'(1);
                end else begin
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                // A >= B after the swap, so the difference is never negative.
                if (diff_q) sum_d = {1'b0, mant_a_q} - {1'b0, mant_b_q};
                else        sum_d = {1'b0, mant_a_q} + {1'b0, mant_b_q};
                state_d = S_NORM;
            end
            S_NORM: begin
                if (sum_q == '0) begin
                    sign_d  = 1'b0;
                    exp_d   = '0;
                    state_d = S_DONE;
                end else if (sum_q[S_W-1]) begin
                    if (exp_q == '1) begin
                        exp_d   = '1;
                        sum_d   = SAT_SUM;
                        ovf_n_d = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        sum_d = {1'b0, sum_q[S_W-1:2], sum_q[1] | sum_q[0]};
                        exp_d = exp_q + EXP_W'(1);
                    end
                end else if (!sum_q[S_W-2]) begin
                    if (exp_q <= EXP_W'(1)) begin
                        sign_d  = 1'b0;
                        exp_d   = '0;
                        sum_d   = '0;
                        unf_n_d = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        sum_d = {sum_q[S_W-2:0], 1'b0};
                        exp_d = exp_q - EXP_W'(1);
                    end
                end else begin
`ifdef FP_ADDER_SEQ_RNE_EN
                    state_d = S_ROUND;
`else
                    state_d = S_DONE;
`endif
                end
            end
`ifdef FP_ADDER_SEQ_RNE_EN
            S_ROUND: begin
                if (rnd[FRAC_W+1]) begin
                    // Rounding carried out of the mantissa: renormalise by one.
                    if (exp_q == '1) begin
                        exp_d   = '1;
                        sum_d   = SAT_SUM;
                        ovf_n_d = 1'b1;
                    end else begin
                        sum_d = {1'b0, rnd[FRAC_W+1:1], 3'b000};
                        exp_d = exp_q + EXP_W'(1);
                    end
                end else begin
                    sum_d = {1'b0, rnd[FRAC_W:0], 3'b000};
                end
                state_d = S_DONE;
            end
`endif
            S_DONE: begin
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    sign_out_d  = sign_q;
                    exp_out_d   = exp_q;
                    frac_out_d  = sum_q[S_W-3:3];
                    ovf_d       = ovf_n_q;
                    unf_d       = unf_n_q;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset abandons any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            sign_q      <= 1'b0;
            diff_q      <= 1'b0;
            exp_q       <= '0;
            mant_a_q    <= '0;
            mant_b_q    <= '0;
            sum_q       <= '0;
            d_q         <= '0;
            ovf_n_q     <= 1'b0;
            unf_n_q     <= 1'b0;
            out_valid_q <= 1'b0;
            sign_out_q  <= 1'b0;
            exp_out_q   <= '0;
            frac_out_q  <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            diff_q      <= diff_d;
            exp_q       <= exp_d;
            mant_a_q    <= mant_a_d;
            mant_b_q    <= mant_b_d;
            sum_q       <= sum_d;
            d_q         <= d_d;
            ovf_n_q     <= ovf_n_d;
            unf_n_q     <= unf_n_d;
            out_valid_q <= out_valid_d;
            sign_out_q  <= sign_out_d;
            exp_out_q   <= exp_out_d;
            frac_out_q  <= frac_out_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
        end
    end

endmodule

// File: tb/tb_fp_adder_seq.sv
// Directed testbench for fp_adder_seq (EXP_W=4, FRAC_W=8, bias 7).
// Results are compared as one packed word {sign, exp, frac, ovf, unf}.
module tb_fp_adder_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic       op_sub;
    logic       sign_a, sign_b;
    logic [3:0] exp_a, exp_b;
    logic [7:0] frac_a, frac_b;
    logic       out_valid;
    logic       out_ready;
    logic       sign_out;
    logic [3:0] exp_out;
    logic [7:0] frac_out;
    logic       ovf, unf;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef FP_ADDER_SEQ_RNE_EN
    localparam int RL = 1;
`else
    localparam int RL = 0;
`endif

    fp_adder_seq #(.EXP_W(4), .FRAC_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .op_sub(op_sub),
        .sign_a(sign_a), .exp_a(exp_a), .frac_a(frac_a),
        .sign_b(sign_b), .exp_b(exp_b), .frac_b(frac_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .sign_out(sign_out), .exp_out(exp_out), .frac_out(frac_out),
        .ovf(ovf), .unf(unf)
    );

    always #5 clk = ~clk;

    function automatic logic [14:0] pack(input logic s, input logic [3:0] e, input logic [7:0] f,
                                         input logic o, input logic u);
        return {s, e, f, o, u};
    endfunction

    // Presents one operand pair, waits for out_valid, optionally completes the handshake.
    task automatic run_op(input logic sub, input logic sa, input logic [3:0] ea, input logic [7:0] fa,
                          input logic sb, input logic [3:0] eb, input logic [7:0] fb,
                          input bit release_out, output logic [14:0] res, output int lat);
        @(negedge clk);
        op_sub = sub; sign_a = sa; exp_a = ea; frac_a = fa;
        sign_b = sb; exp_b = eb; frac_b = fb;
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        n_cmp++;
        if (lat >= 100) begin
            n_bad++;
            $display("FAIL timeout: out_valid=%b after %0d cycles, required 1", out_valid, lat);
        end
        res = pack(sign_out, exp_out, frac_out, ovf, unf);
        $display("op %0d: (%0d,%0d,%h) %s (%0d,%0d,%h) -> (%0d,%0d,%h) ovf=%b unf=%b lat=%0d",
                 n_cmp, sa, ea, fa, sub ? "-" : "+", sb, eb, fb, sign_out, exp_out, frac_out, ovf, unf, lat);
        if (release_out) begin
            @(negedge clk); out_ready = 1'b1;
            @(posedge clk); #1; out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op_sub = 1'b0;
        sign_a = 1'b0; exp_a = '0; frac_a = '0; sign_b = 1'b0; exp_b = '0; frac_b = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (pack(sign_out, exp_out, frac_out, ovf, unf) !== 15'h0) begin
            n_bad++; $display("FAIL reset_outputs: got %h want 0000", pack(sign_out, exp_out, frac_out, ovf, unf));
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL idle_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_add();
        logic [14:0] r; int lat;
        // 1.0 + 1.0 = 2.0: one carry shift in NORM.
        run_op(0, 0, 4'd7, 8'h00, 0, 4'd7, 8'h00, 1, r, lat);
        n_cmp++; if (r !== pack(0, 4'd8, 8'h00, 0, 0)) begin n_bad++; $display("FAIL add_1p1: got %h want %h", r, pack(0, 4'd8, 8'h00, 0, 0)); end
        n_cmp++; if (lat !== 5 + RL) begin n_bad++; $display("FAIL lat_1p1: got %0d want %0d", lat, 5 + RL); end
        // 1.5 + 0.5 = 2.0 with d=1, and the swapped order.
        run_op(0, 0, 4'd7, 8'h80, 0, 4'd6, 8'h00, 1, r, lat);
        n_cmp++; if (r !== pack(0, 4'd8, 8'h00, 0, 0)) begin n_bad++; $display("FAIL add_1p5: got %h want %h", r, pack(0, 4'd8, 8'h00, 0, 0)); end
        n_cmp++; if (lat !== 6 + RL) begin n_bad++; $display("FAIL lat_1p5: got %0d want %0d", lat, 6 + RL); end
        run_op(0, 0, 4'd6, 8'h00, 0, 4'd7, 8'h80, 1, r, lat);
        n_cmp++; if (r !== pack(0, 4'd8, 8'h00, 0, 0)) begin n_bad++; $display("FAIL add_swap: got %h want %h", r, pack(0, 4'd8, 8'h00, 0, 0)); end
    endtask

    task automatic test_sub();
        logic [14:0] r; int lat;
        // 1.0 - 1.0 = +0, zero result skips any rounding.
        run_op(1, 0, 4'd7, 8'h00, 0, 4'd7, 8'h00, 1, r, lat);
        n_cmp++; if (r !== pack(0, 4'd0, 8'h00, 0, 0)) begin n_bad++; $display("FAIL sub_zero: got %h want %h", r, pack(0, 4'd0, 8'h00, 0, 0)); end
        n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL lat_sub_zero: got %0d want 4", lat); end
        // 4.0 - 3.9921875 = 2^-7: below the smallest normal (2^-6), so it is flushed to +0 with unf.
        run_op(1, 0, 4'd9, 8'h00, 0, 4'd8, 8'hFF, 1, r, lat);
        n_cmp++; if (r !== pack(0, 4'd0, 8'h00, 0, 1)) begin n_bad++; $display("FAIL sub_tiny: got %h want %h", r, pack(0, 4'd0, 8'h00, 0, 1)); end
        // 1.0 - 2.0 = -1.0: operands swapped, one left shift.
        run_op(1, 0, 4'd7, 8'h00, 0, 4'd8, 8'h00, 1, r, lat);
        n_cmp++; if (r !== pack(1, 4'd7, 8'h00, 0, 0)) begin n_bad++; $display("FAIL sub_neg: got %h want %h", r, pack(1, 4'd7, 8'h00, 0, 0)); end
        n_cmp++; if (lat !== 6 + RL) begin n_bad++; $display("FAIL lat_sub_neg: got %0d want %0d", lat, 6 + RL); end
    endtask

    task automatic test_saturate_and_shift();
        logic [14:0] r; int lat;
        run_op(0, 0, 4'd15, 8'hFF, 0, 4'd15, 8'hFF, 1, r, lat);
        n_cmp++; if (r !== pack(0, 4'd15, 8'hFF, 1, 0)) begin n_bad++; $display("FAIL saturate: got %h want %h", r, pack(0, 4'd15, 8'hFF, 1, 0)); end
        // Gap of 13 is capped at 11; B survives only as sticky.
        run_op(0, 0, 4'd14, 8'h00, 0, 4'd1, 8'h00, 1, r, lat);
        n_cmp++; if (r !== pack(0, 4'd14, 8'h00, 0, 0)) begin n_bad++; $display("FAIL big_shift: got %h want %h", r, pack(0, 4'd14, 8'h00, 0, 0)); end
        n_cmp++; if (lat !== 15 + RL) begin n_bad++; $display("FAIL lat_big_shift: got %0d want %0d", lat, 15 + RL); end
    endtask

    task automatic test_round();
        logic [14:0] r; int lat;
        logic [7:0] f_exp; logic [3:0] e_exp;
        // Guard-only tie with odd lsb: rounds up to even under RNE.
        f_exp = (RL == 1) ? 8'h02 : 8'h01;
        run_op(0, 0, 4'd15, 8'h01, 0, 4'd6, 8'h00, 1, r, lat);
        n_cmp++; if (r !== pack(0, 4'd15, f_exp, 0, 0)) begin n_bad++; $display("FAIL round_odd: got %h want %h", r, pack(0, 4'd15, f_exp, 0, 0)); end
        // Tie with even lsb stays put in both builds.
        run_op(0, 0, 4'd15, 8'h00, 0, 4'd6, 8'h00, 1, r, lat);
        n_cmp++; if (r !== pack(0, 4'd15, 8'h00, 0, 0)) begin n_bad++; $display("FAIL round_even: got %h want %h", r, pack(0, 4'd15, 8'h00, 0, 0)); end
        // Rounding up 1.11111111 carries into the exponent.
        f_exp = (RL == 1) ? 8'h00 : 8'hFF;
        e_exp = (RL == 1) ? 4'd11 : 4'd10;
        run_op(0, 0, 4'd10, 8'hFF, 0, 4'd1, 8'h00, 1, r, lat);
        n_cmp++; if (r !== pack(0, e_exp, f_exp, 0, 0)) begin n_bad++; $display("FAIL round_carry: got %h want %h", r, pack(0, e_exp, f_exp, 0, 0)); end
    endtask

    task automatic test_back_to_back();
        logic [14:0] r; int lat;
        run_op(0, 0, 4'd7, 8'h80, 0, 4'd6, 8'h00, 0, r, lat);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                n_bad++; $display("FAIL hold_ctrl: got valid=%b ready=%b want 1/0", out_valid, in_ready);
            end
            n_cmp++; if (pack(sign_out, exp_out, frac_out, ovf, unf) !== pack(0, 4'd8, 8'h00, 0, 0)) begin
                n_bad++; $display("FAIL hold_data: got %h want %h", pack(sign_out, exp_out, frac_out, ovf, unf), pack(0, 4'd8, 8'h00, 0, 0));
            end
        end
        // New operands offered in the handshake cycle must not be taken then.
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; op_sub = 1'b0;
        sign_a = 1'b0; exp_a = 4'd7; frac_a = 8'h00; sign_b = 1'b0; exp_b = 4'd7; frac_b = 8'h00;
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++; $display("FAIL release: got valid=%b ready=%b want 0/1", out_valid, in_ready);
        end
        n_cmp++; if (pack(sign_out, exp_out, frac_out, ovf, unf) !== pack(0, 4'd8, 8'h00, 0, 0)) begin
            n_bad++; $display("FAIL release_data: got %h want %h", pack(sign_out, exp_out, frac_out, ovf, unf), pack(0, 4'd8, 8'h00, 0, 0));
        end
    endtask

    task automatic test_reset_mid();
        logic [14:0] r; int lat;
        @(negedge clk);
        op_sub = 1'b0; sign_a = 1'b0; exp_a = 4'd14; frac_a = 8'h00; sign_b = 1'b0; exp_b = 4'd1; frac_b = 8'h00;
        in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2; rst = 1'b1; #1;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++; $display("FAIL mid_reset: got valid=%b ready=%b want 0/1", out_valid, in_ready);
        end
        $display("reset asserted during ALIGN: valid=%b ready=%b", out_valid, in_ready);
        @(negedge clk); rst = 1'b0;
        run_op(0, 0, 4'd7, 8'h80, 0, 4'd6, 8'h00, 1, r, lat);
        n_cmp++; if (r !== pack(0, 4'd8, 8'h00, 0, 0)) begin n_bad++; $display("FAIL after_reset: got %h want %h", r, pack(0, 4'd8, 8'h00, 0, 0)); end
        n_cmp++; if (lat !== 6 + RL) begin n_bad++; $display("FAIL lat_after_reset: got %0d want %0d", lat, 6 + RL); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_saturate_and_shift();
        test_round();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
